multiply_by_quantized_multiplier: RTL and testbench
===================================================

// Module: multiply_by_quantized_multiplier
// PURPOSE
//  Fixed-point requantizer for the NPU int8 datapath (TFLite-style MultiplyByQuantizedMultiplier).
//  Scales a 32-bit accumulator by a Q31 multiplier and a signed power-of-two shift.
//  Rounds, then applies the int8 saturation rules below. Fully pipelined: one input per cycle, in-order results.
// PARAMETERS
//  QMIN  -128  lower int8 saturation bound (signed 32-bit)
//  QMAX   127  upper int8 saturation bound (signed 32-bit)
// PORTS
//  clk                            in   1   clock, rising edge
//  rst                            in   1   asynchronous, active-high reset
//  input_valid                    in   1   x/quantized_multiplier/shift valid this cycle
//  x                              in   32  signed accumulator
//  quantized_multiplier           in   32  Q31 multiplier, treated as signed
//  shift                          in   32  signed exponent; >0 = left shift, <=0 = right shift
//  output_valid                   out  1   result valid
//  x_mul_by_quantized_multiplier  out  32  signed result
// BEHAVIOUR
//  Reset: output_valid=0, x_mul_by_quantized_multiplier=0, all pipeline valids cleared; in-flight data dropped.
//  Latency: exactly 3 cycles; output_valid is input_valid delayed 3 clocks.
//  No backpressure. A sample is accepted on every rising edge with input_valid=1. Data is don't-care when valid=0.
//  Shift decode:
//   ls = shift>0 ? shift : 0
//   rs = shift>0 ? 0 : -shift
//   ls and rs are saturated to 31.
//  ab = sext64(x) * 2^ls * sext64(qm): signed 64-bit, wrapping.
//  ovf = (x == qm == 32'h8000_0000).
//  nudge: 31-bit signed constant. It is -2^30 when ab>=0, and -(2^30-1) when ab<0.
//  hi = ovf ? 32'h7FFF_FFFF : low32((ab + sext64(nudge)) >>> 31).
//  Early saturation, only when rs!=0. Bounds use 32-bit signed arithmetic:
//   if ab < (QMIN<<rs): result = QMIN
//   else if ab > (QMAX<<rs): result = QMAX
//  Otherwise, rounding divide:
//   mask = 2^rs - 1; rem = hi & mask; thr = (mask>>1) + (hi<0).
//   t = hi >>> rs
//   if rem > thr: result = t>=QMAX ? QMAX : (t<QMIN ? QMIN : t+1)
//   else: result = t (NOT clamped)
//  When rs=0 the result is hi unclamped (full 32-bit), e.g. for left shifts.
// CONFIGURATION
//  QUANT_FULL_CLAMP_EN:
//   defined: the final result is always clamped to [QMIN,QMAX], in every path.
//   undefined (default): exact rules above, i.e. unclamped on the rs=0 and no-round-up paths.
// STRUCTURE
//  Shared package quant_pkg holds QMIN/QMAX defaults, the NUDGE_POS/NUDGE_NEG constants and the shift-saturation limit 31.
//  Pipeline stages:
//   S1: shift decode, x<<ls, early-saturation bound compare setup
//   S2: 64x32 signed multiply, registered
//   S3: rounding, divide and saturation, registered
//  Sub-module sat_round_dbl_high_mul (S2/S3 core producing hi and ab flags).
// TESTING
//  x=-6506, qm=32'h0001_0000, shift=-12 -> -128 (early saturation).
//  x=14539, qm=32'h0400_0000, shift=3 -> 3634.
//  x=-6506, qm=32'h4000_0000, shift=3 -> -26025. x=14539, same qm/shift -> 58155.
//  qm=1591541760, shift=22:
//   x=-7 -> -21759361
//   x=-3 -> -9325441
//   x=-6 -> -18650881
//   x=4 -> 12433919
//  Back-to-back: the 8 vectors above on consecutive cycles -> 8 results in order, each 3 cycles after its input.
//  rst pulse mid-stream -> output_valid=0 next cycle, no stale results emerge; x=qm=32'h8000_0000, shift=0 -> 32'h7FFF_FFFF.

Source files
------------

// File: rtl/quant_pkg.sv
// Shared constants and shift decode for the int8 requantizer pipeline.
// Consumed by multiply_by_quantized_multiplier (optional macro QUANT_FULL_CLAMP_EN).
package quant_pkg;

  localparam logic signed [31:0] QMIN_DEFAULT = -32'sd128;
  localparam logic signed [31:0] QMAX_DEFAULT = 32'sd127;

  // Both nudges are negative: -2^30 for ab >= 0, -(2^30-1) for ab < 0 (31-bit signed).
  localparam logic signed [30:0] NUDGE_POS = 31'sh4000_0000;
  localparam logic signed [30:0] NUDGE_NEG = 31'sh4000_0001;

  localparam logic signed [31:0] SHIFT_SAT = 32'sd31;

  typedef struct packed {
    logic [4:0] ls;
    logic [4:0] rs;
  } shift_dec_t;

  function automatic shift_dec_t decode_shift(input logic signed [31:0] shift);
    shift_dec_t d;
    d.ls = '0;
    d.rs = '0;
    if (shift > 32'sd0) begin
      d.ls = (shift > SHIFT_SAT) ? 5'(SHIFT_SAT) : 5'(shift);
    end else begin
      d.rs = (shift < -SHIFT_SAT) ? 5'(SHIFT_SAT) : 5'(-shift);
    end
    return d;
  endfunction

endpackage

// File: rtl/sat_round_dbl_high_mul.sv
// S2 wide multiply register plus the nudged high-word extraction and
// early-saturation bound flags consumed by the final rounding stage.
module sat_round_dbl_high_mul
  import quant_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [63:0] i_x_shl,
  input  logic [31:0] i_qm,
  input  logic        i_ovf,
  input  logic [31:0] i_lo_bound,
  input  logic [31:0] i_hi_bound,
  output logic [31:0] o_hi,
  output logic        o_below_min,
  output logic        o_above_max
);

  logic signed [63:0] r_ab;
  logic               r_ovf;
  logic [31:0]        r_lo_bound;
  logic [31:0]        r_hi_bound;
  logic signed [63:0] w_prod;
  logic signed [63:0] w_nudge;

  // Product is kept modulo 2^64, matching the wrapping reference behaviour.
  assign w_prod = $signed(i_x_shl) * $signed({{32{i_qm[31]}}, i_qm});

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ab       <= '0;
      r_ovf      <= 1'b0;
      r_lo_bound <= '0;
      r_hi_bound <= '0;
    end else begin
      r_ab       <= w_prod;
      r_ovf      <= i_ovf;
      r_lo_bound <= i_lo_bound;
      r_hi_bound <= i_hi_bound;
    end
  end

  assign w_nudge = r_ab[63] ? {{33{NUDGE_NEG[30]}}, NUDGE_NEG}
                            : {{33{NUDGE_POS[30]}}, NUDGE_POS};

  assign o_hi        = r_ovf ? 32'h7FFF_FFFF : 32'((r_ab + w_nudge) >>> 31);
  assign o_below_min = r_ab < $signed({{32{r_lo_bound[31]}}, r_lo_bound});
  assign o_above_max = r_ab > $signed({{32{r_hi_bound[31]}}, r_hi_bound});

endmodule

// File: rtl/multiply_by_quantized_multiplier.sv
// Three-stage TFLite-style requantizer: x * Q31 multiplier * 2^shift, rounded and saturated.
// Define QUANT_FULL_CLAMP_EN to clamp every result into [QMIN, QMAX].
module multiply_by_quantized_multiplier
  import quant_pkg::*;
#(
  parameter logic signed [31:0] QMIN = QMIN_DEFAULT,
  parameter logic signed [31:0] QMAX = QMAX_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        input_valid,
  input  logic [31:0] x,
  input  logic [31:0] quantized_multiplier,
  input  logic [31:0] shift,
  output logic        output_valid,
  output logic [31:0] x_mul_by_quantized_multiplier
);

  shift_dec_t         w_dec;
  logic [63:0]        w_x_shl;
  logic               w_ovf;
  logic [31:0]        w_lo_bound;
  logic [31:0]        w_hi_bound;

  logic               r_s1_valid;
  logic [63:0]        r_s1_x_shl;
  logic [31:0]        r_s1_qm;
  logic               r_s1_ovf;
  logic [31:0]        r_s1_lo_bound;
  logic [31:0]        r_s1_hi_bound;
  logic [4:0]         r_s1_rs;

  logic               r_s2_valid;
  logic [4:0]         r_s2_rs;

  logic               r_s3_valid;
  logic [31:0]        r_s3_result;

  logic signed [31:0] w_hi;
  logic               w_below;
  logic               w_above;
  logic [31:0]        w_mask;
  logic [31:0]        w_rem;
  logic [31:0]        w_thr;
  logic signed [31:0] w_t;
  logic signed [31:0] w_result;
  logic signed [31:0] w_final;

  // S1: shift decode, pre-shift of x, bounds computed with 32-bit wraparound.
  assign w_dec      = decode_shift(shift);
  assign w_x_shl    = {{32{x[31]}}, x} << w_dec.ls;
  assign w_ovf      = (x == 32'h8000_0000) && (quantized_multiplier == 32'h8000_0000);
  assign w_lo_bound = QMIN << w_dec.rs;
  assign w_hi_bound = QMAX << w_dec.rs;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_valid    <= 1'b0;
      r_s1_x_shl    <= '0;
      r_s1_qm       <= '0;
      r_s1_ovf      <= 1'b0;
      r_s1_lo_bound <= '0;
      r_s1_hi_bound <= '0;
      r_s1_rs       <= '0;
      r_s2_valid    <= 1'b0;
      r_s2_rs       <= '0;
      r_s3_valid    <= 1'b0;
      r_s3_result   <= '0;
    end else begin
      r_s1_valid    <= input_valid;
      r_s1_x_shl    <= w_x_shl;
      r_s1_qm       <= quantized_multiplier;
      r_s1_ovf      <= w_ovf;
      r_s1_lo_bound <= w_lo_bound;
      r_s1_hi_bound <= w_hi_bound;
      r_s1_rs       <= w_dec.rs;
      r_s2_valid    <= r_s1_valid;
      r_s2_rs       <= r_s1_rs;
      r_s3_valid    <= r_s2_valid;
      r_s3_result   <= w_final;
    end
  end

  sat_round_dbl_high_mul u_core (
    .clk         (clk),
    .rst         (rst),
    .i_x_shl     (r_s1_x_shl),
    .i_qm        (r_s1_qm),
    .i_ovf       (r_s1_ovf),
    .i_lo_bound  (r_s1_lo_bound),
    .i_hi_bound  (r_s1_hi_bound),
    .o_hi        (w_hi),
    .o_below_min (w_below),
    .o_above_max (w_above)
  );

  assign w_mask = (32'd1 << r_s2_rs) - 32'd1;
  assign w_rem  = w_hi & w_mask;
  assign w_thr  = (w_mask >> 1) + {31'd0, w_hi[31]};
  assign w_t    = w_hi >>> r_s2_rs;

  // With rs == 0 the mask is zero, so this naturally yields hi unclamped.
  always_comb begin
    w_result = w_t;
    if ((r_s2_rs != 5'd0) && w_below) begin
      w_result = QMIN;
    end else if ((r_s2_rs != 5'd0) && w_above) begin
      w_result = QMAX;
    end else if (w_rem > w_thr) begin
      if (w_t >= QMAX) begin
        w_result = QMAX;
      end else if (w_t < QMIN) begin
        w_result = QMIN;
      end else begin
        w_result = w_t + 32'sd1;
      end
    end
  end

`ifdef QUANT_FULL_CLAMP_EN
  always_comb begin
    w_final = w_result;
    if (w_result > QMAX) begin
      w_final = QMAX;
    end else if (w_result < QMIN) begin
      w_final = QMIN;
    end
  end
`else
  assign w_final = w_result;
`endif

  assign output_valid                  = r_s3_valid;
  assign x_mul_by_quantized_multiplier = r_s3_result;

endmodule

// File: tb/tb_multiply_by_quantized_multiplier.sv
// Scoreboard bench for the requantizer: expected results queued at drive time,
// popped and compared when output_valid is due (exactly 3 cycles later).
`timescale 1ns/1ps
module tb_multiply_by_quantized_multiplier;

  localparam int QMIN = -128;
  localparam int QMAX = 127;

  logic        clk = 1'b0;
  logic        rst;
  logic        input_valid;
  logic [31:0] x;
  logic [31:0] qm;
  logic [31:0] shift;
  logic        output_valid;
  logic [31:0] y;

  typedef struct {
    logic [31:0] data;
    int          due;
    int          id;
  } exp_t;

  exp_t q[$];
  int   cyc      = 0;
  int   next_id  = 0;
  int   n_checks = 0;
  int   n_fails  = 0;

  int sx [8] = '{-6506, 14539, -6506, 14539, -7, -3, -6, 4};
  int sq [8] = '{32'h0001_0000, 32'h0400_0000, 32'h4000_0000, 32'h4000_0000,
                 1591541760, 1591541760, 1591541760, 1591541760};
  int ss [8] = '{-12, 3, 3, 3, 22, 22, 22, 22};
  int se [8] = '{-128, 3634, -26025, 58155, -21759361, -9325441, -18650881, 12433919};

  always #5 clk = ~clk;

  multiply_by_quantized_multiplier dut (
    .clk                           (clk),
    .rst                           (rst),
    .input_valid                   (input_valid),
    .x                             (x),
    .quantized_multiplier          (qm),
    .shift                         (shift),
    .output_valid                  (output_valid),
    .x_mul_by_quantized_multiplier (y)
  );

  function automatic int fc(input int v);
`ifdef QUANT_FULL_CLAMP_EN
    if (v > QMAX) return QMAX;
    if (v < QMIN) return QMIN;
`endif
    return v;
  endfunction

  function automatic int ref_model(input int xi, input int qi, input int si);
    int     ls, rs, hi, lob, hib, mask, rem, thr, t;
    longint ab, nudge;
    bit     ovf;
    ls = (si > 0) ? ((si > 31) ? 31 : si) : 0;
    rs = (si > 0) ? 0 : ((si < -31) ? 31 : -si);
    ab = longint'(xi) * (longint'(1) << ls) * longint'(qi);
    ovf = (xi == int'(32'h8000_0000)) && (qi == int'(32'h8000_0000));
    nudge = (ab >= 0) ? -longint'(1 << 30) : -longint'((1 << 30) - 1);
    hi = ovf ? int'(32'h7FFF_FFFF) : int'((ab + nudge) >>> 31);
    if (rs != 0) begin
      lob = QMIN <<< rs;
      hib = QMAX <<< rs;
      if (ab < longint'(lob)) return fc(QMIN);
      if (ab > longint'(hib)) return fc(QMAX);
    end
    mask = int'((longint'(1) << rs) - 1);
    rem  = hi & mask;
    thr  = (mask >>> 1) + ((hi < 0) ? 1 : 0);
    t    = hi >>> rs;
    if (rem > thr) begin
      if (t >= QMAX) return fc(QMAX);
      if (t < QMIN) return fc(QMIN);
      return fc(t + 1);
    end
    return fc(t);
  endfunction

  task automatic check_output();
    logic exp_valid;
    exp_t e;
    exp_valid = (q.size() > 0) && (q[0].due == cyc);
    n_checks++;
    assert (output_valid === exp_valid) else begin
      n_fails++;
      $error("FAIL output_valid@cyc%0d: got %b expected %b", cyc, output_valid, exp_valid);
    end
    if (exp_valid) begin
      e = q.pop_front();
      n_checks++;
      assert (y === e.data) else begin
        n_fails++;
        $error("FAIL result#%0d: got %0d (0x%08h) expected %0d (0x%08h)",
               e.id, $signed(y), y, $signed(e.data), e.data);
      end
    end
  endtask

  task automatic step(input logic v, input int xi, input int qi, input int si, input int expv);
    exp_t e;
    input_valid = v;
    x           = xi;
    qm          = qi;
    shift       = si;
    if (v) begin
      e.data = expv;
      e.due  = cyc + 3;
      e.id   = next_id;
      next_id++;
      q.push_back(e);
      $display("drive #%0d x=%0d qm=0x%08h shift=%0d expect=%0d", e.id, xi, qi, si, expv);
    end
    @(negedge clk);
    check_output();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, int'($urandom()), int'($urandom()), int'($urandom()), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int xv, qv, sv;
    rst = 1'b1; input_valid = 1'b0; x = '0; qm = '0; shift = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_checks++;
    assert (output_valid === 1'b0) else begin
      n_fails++; $error("FAIL reset_valid: got %b expected 0", output_valid);
    end
    n_checks++;
    assert (y === 32'd0) else begin
      n_fails++; $error("FAIL reset_data: got 0x%08h expected 0x00000000", y);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Isolated spec vectors, then the same eight back-to-back.
    for (int i = 0; i < 8; i++) begin
      step(1'b1, sx[i], sq[i], ss[i], fc(se[i]));
      idle(3);
    end
    for (int i = 0; i < 8; i++) step(1'b1, sx[i], sq[i], ss[i], fc(se[i]));
    idle(4);

    // Shift saturation and sign boundaries.
    step(1'b1, 12345678, 32'h5A5A_5A5A, -31, ref_model(12345678, 32'h5A5A_5A5A, -31));
    step(1'b1, -987654321, 32'h7FFF_FFFF, -100, ref_model(-987654321, 32'h7FFF_FFFF, -100));
    step(1'b1, 3, 32'h4000_0000, 31, ref_model(3, 32'h4000_0000, 31));
    step(1'b1, -5, 32'h6000_0000, 40, ref_model(-5, 32'h6000_0000, 40));
    step(1'b1, 255, 32'h4000_0000, -1, ref_model(255, 32'h4000_0000, -1));
    step(1'b1, 253, 32'h4000_0000, -1, ref_model(253, 32'h4000_0000, -1));
    step(1'b1, -257, 32'h4000_0000, -1, ref_model(-257, 32'h4000_0000, -1));
    step(1'b1, 32'h8000_0000, 32'h8000_0000, -5, ref_model(32'h8000_0000, 32'h8000_0000, -5));
    step(1'b1, 32'h8000_0000, 32'h8000_0000, 4, ref_model(32'h8000_0000, 32'h8000_0000, 4));
    step(1'b1, 32'h7FFF_FFFF, 32'h8000_0000, 0, ref_model(32'h7FFF_FFFF, 32'h8000_0000, 0));
    idle(3);

    // Random mix with occasional bubbles.
    for (int i = 0; i < 48; i++) begin
      case ($urandom_range(0, 3))
        0:       xv = int'($urandom_range(0, 40000)) - 20000;
        1:       xv = int'($urandom());
        2:       xv = int'($urandom_range(0, 20)) - 10;
        default: xv = ($urandom_range(0, 1) == 1) ? int'(32'h7FFF_FFFF) : int'(32'h8000_0000);
      endcase
      qv = ($urandom_range(0, 1) == 1) ? int'($urandom()) : int'($urandom_range(32'h4000_0000, 32'h7FFF_FFFF));
      sv = int'($urandom_range(0, 80)) - 40;
      step(1'b1, xv, qv, sv, ref_model(xv, qv, sv));
      if ($urandom_range(0, 4) == 0) idle(1);
    end
    idle(4);

    // Reset mid-stream: in-flight samples must be dropped.
    step(1'b1, sx[1], sq[1], ss[1], fc(se[1]));
    step(1'b1, sx[2], sq[2], ss[2], fc(se[2]));
    q.delete();
    rst = 1'b1;
    input_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    assert (output_valid === 1'b0) else begin
      n_fails++; $error("FAIL midrst_valid: got %b expected 0", output_valid);
    end
    n_checks++;
    assert (y === 32'd0) else begin
      n_fails++; $error("FAIL midrst_data: got 0x%08h expected 0x00000000", y);
    end
    @(posedge clk);
    #1;
    cyc++;
    rst = 1'b0;
    idle(5);
    step(1'b1, 32'h8000_0000, 32'h8000_0000, 0, fc(int'(32'h7FFF_FFFF)));

    for (int k = 0; k < 10 && q.size() > 0; k++) idle(1);
    n_checks++;
    assert (q.size() == 0) else begin
      n_fails++; $error("FAIL drain: got %0d pending results expected 0", q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
